// File: rtl/full_subtractor_pkg.sv
// Shared types and constants for the registered ripple-borrow subtractor.
// The FULL_SUBTRACTOR_BORROW_COUNT_EN build uses the counter type and saturating helper.
package full_subtractor_pkg;

    localparam int BORR_CNT_W = 16;
    localparam logic [BORR_CNT_W-1:0] BORR_CNT_MAX = 16'hFFFF;

    typedef logic [BORR_CNT_W-1:0] borr_cnt_t;

    // Saturating increment: holds at BORR_CNT_MAX instead of wrapping.
    function automatic borr_cnt_t borr_cnt_sat_inc(input borr_cnt_t value);
        borr_cnt_t result;
        if (value == BORR_CNT_MAX) begin
            result = value;
        end else begin
            result = value + borr_cnt_t'(1'b1);
        end
        return result;
    endfunction

endpackage

// File: rtl/full_subtractor_unit_if.sv
// Operand/result bundle for full_subtractor_unit.
// borr_cnt exists only when FULL_SUBTRACTOR_BORROW_COUNT_EN is defined.
interface full_subtractor_unit_if
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] diff;
    logic             borr;
    logic             out_valid;
`ifdef FULL_SUBTRACTOR_BORROW_COUNT_EN
    borr_cnt_t        borr_cnt;

    modport master (
        output in_valid, a, b, c,
        input  diff, borr, out_valid, borr_cnt
    );

    modport slave (
        input  in_valid, a, b, c,
        output diff, borr, out_valid, borr_cnt
    );
`else
    modport master (
        output in_valid, a, b, c,
        input  diff, borr, out_valid
    );

    modport slave (
        input  in_valid, a, b, c,
        output diff, borr, out_valid
    );
`endif

endinterface

// File: rtl/full_subtractor_bit.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_subtractor_unit.sv
// Registered ripple-borrow subtractor: {borr, diff} = a - b - c, one cycle latency.
// Optional saturating borrow counter under FULL_SUBTRACTOR_BORROW_COUNT_EN.
module full_subtractor_unit
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    full_subtractor_unit_if.slave bus
);

    logic [WIDTH:0]   borrow_chain_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] diff_r;
    logic             borr_r;
    logic             out_valid_r;

    assign borrow_chain_s[0] = bus.c;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i = i + 1) begin : g_cell
            full_subtractor_bit u_bit (
                .a    (bus.a[i]),
                .b    (bus.b[i]),
                .bin  (borrow_chain_s[i]),
                .d    (diff_s[i]),
                .bout (borrow_chain_s[i+1])
            );
        end
    endgenerate

    // Result registers: load on valid, hold otherwise; out_valid marks a fresh load.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_r      <= {WIDTH{1'b0}};
            borr_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (bus.in_valid) begin
            diff_r      <= diff_s;
            borr_r      <= borrow_chain_s[WIDTH];
            out_valid_r <= 1'b1;
        end else begin
            diff_r      <= diff_r;
            borr_r      <= borr_r;
            out_valid_r <= 1'b0;
        end
    end

    assign bus.diff      = diff_r;
    assign bus.borr      = borr_r;
    assign bus.out_valid = out_valid_r;

`ifdef FULL_SUBTRACTOR_BORROW_COUNT_EN
    borr_cnt_t borr_cnt_r;

    // Counts accepted results whose computed borrow is set, saturating at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            borr_cnt_r <= {BORR_CNT_W{1'b0}};
        end else if (bus.in_valid && borrow_chain_s[WIDTH]) begin
            borr_cnt_r <= borr_cnt_sat_inc(borr_cnt_r);
        end else begin
            borr_cnt_r <= borr_cnt_r;
        end
    end

    assign bus.borr_cnt = borr_cnt_r;
`endif

endmodule

// File: tb/tb_full_subtractor_unit.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 instances, queue scoreboard, directed steps.
module tb_full_subtractor_unit;

    typedef struct packed {
        logic [7:0] d;
        logic       b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exp_t q1[$];
    exp_t q8[$];
    exp_t last1 = '0;
    exp_t last8 = '0;
    logic [15:0] cnt1 = 16'h0000;
    logic [15:0] cnt8 = 16'h0000;

    always #5 clk = ~clk;

    full_subtractor_unit_if #(.WIDTH(1)) bus1 ();
    full_subtractor_unit_if #(.WIDTH(8)) bus8 ();

    full_subtractor_unit #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    full_subtractor_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] r;
        r = {1'b0, a} - {1'b0, b} - {8'h00, c};
        return '{d: r[7:0], b: r[8]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sat_inc(inout logic [15:0] v);
        if (v != 16'hFFFF) v = v + 16'h0001;
    endtask

    task automatic chk_out1(input logic ev, input string tag);
        chk({tag, "_valid1"}, {31'd0, bus1.out_valid}, {31'd0, ev});
        if (ev) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s_sb1 observed=empty expected=entry", tag);
            end else begin
                last1 = q1.pop_front();
            end
        end
        chk({tag, "_diff1"}, {31'd0, bus1.diff}, {31'd0, last1.d[0]});
        chk({tag, "_borr1"}, {31'd0, bus1.borr}, {31'd0, last1.b});
`ifdef FULL_SUBTRACTOR_BORROW_COUNT_EN
        chk({tag, "_cnt1"}, {16'd0, bus1.borr_cnt}, {16'd0, cnt1});
`endif
    endtask

    task automatic chk_out8(input logic ev, input string tag);
        chk({tag, "_valid8"}, {31'd0, bus8.out_valid}, {31'd0, ev});
        if (ev) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s_sb8 observed=empty expected=entry", tag);
            end else begin
                last8 = q8.pop_front();
            end
        end
        chk({tag, "_diff8"}, {24'd0, bus8.diff}, {24'd0, last8.d});
        chk({tag, "_borr8"}, {31'd0, bus8.borr}, {31'd0, last8.b});
`ifdef FULL_SUBTRACTOR_BORROW_COUNT_EN
        chk({tag, "_cnt8"}, {16'd0, bus8.borr_cnt}, {16'd0, cnt8});
`endif
    endtask

    // One cycle on the WIDTH=1 unit; ed/eb are the expected result when v=1.
    task automatic step1(input logic v, input logic a, input logic b, input logic c,
                         input logic ed, input logic eb, input string tag);
        bus1.in_valid = v;
        bus1.a = a;
        bus1.b = b;
        bus1.c = c;
        bus8.in_valid = 1'b0;
        if (v) begin
            q1.push_back('{d: {7'd0, ed}, b: eb});
            if (eb) sat_inc(cnt1);
        end
        @(posedge clk);
        #1;
        chk_out1(v, tag);
    endtask

    task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c,
                         input exp_t e, input string tag);
        bus8.in_valid = v;
        bus8.a = a;
        bus8.b = b;
        bus8.c = c;
        bus1.in_valid = 1'b0;
        if (v) begin
            q8.push_back(e);
            if (e.b) sat_inc(cnt8);
        end
        @(posedge clk);
        #1;
        chk_out8(v, tag);
    endtask

    // Reset with valid operands presented: the operands must be discarded.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus1.in_valid = 1'b1;
        bus1.a = 1'b1;
        bus1.b = 1'b0;
        bus1.c = 1'b0;
        bus8.in_valid = 1'b1;
        bus8.a = 8'h5A;
        bus8.b = 8'h01;
        bus8.c = 1'b0;
        q1.delete();
        q8.delete();
        last1 = '0;
        last8 = '0;
        cnt1 = 16'h0000;
        cnt8 = 16'h0000;
        @(posedge clk);
        #1;
        chk_out1(1'b0, tag);
        chk_out8(1'b0, tag);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        bus1.in_valid = 1'b0;
        bus1.a = 1'b0;
        bus1.b = 1'b0;
        bus1.c = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.a = 8'h00;
        bus8.b = 8'h00;
        bus8.c = 1'b0;

        do_reset("reset");

        // WIDTH=1 truth table, back-to-back
        step1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "tt000");
        step1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "tt100");
        step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "tt010");
        step1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "tt110");
        step1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "tt001");
        step1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "tt101");
        step1(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "tt011");
        step1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "tt111");

        // Hold: idle cycle with different operands keeps the last result
        step1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "hold_load");
        step1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "hold_idle");
        step1(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "hold_idle2");

        // Back-to-back pair
        step1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_first");
        step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "b2b_second");
        step1(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "b2b_idle");

        // WIDTH=8 boundaries with literal expectations
        step8(1'b1, 8'h00, 8'h01, 1'b0, '{d: 8'hFF, b: 1'b1}, "w8_00m01");
        step8(1'b1, 8'hFF, 8'hFF, 1'b1, '{d: 8'hFF, b: 1'b1}, "w8_FFmFFm1");
        step8(1'b1, 8'h80, 8'h01, 1'b1, '{d: 8'h7E, b: 1'b0}, "w8_80m01m1");
        step8(1'b1, 8'hFF, 8'h00, 1'b0, '{d: 8'hFF, b: 1'b0}, "w8_FFm00");
        step8(1'b0, 8'h12, 8'h34, 1'b1, '{d: 8'h00, b: 1'b0}, "w8_idle");

        // WIDTH=8 pseudo-random operands against the arithmetic model
        for (int k = 0; k < 24; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            step8(1'b1, ra, rb, rc, model8(ra, rb, rc), "w8_rand");
        end
        step8(1'b0, 8'h00, 8'h00, 1'b0, '{d: 8'h00, b: 1'b0}, "w8_tail");

`ifdef FULL_SUBTRACTOR_BORROW_COUNT_EN
        // Drive the borrow counter into saturation, then clear it with reset
        for (int k = 0; k < 70000; k++) begin
            step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "cnt_run");
        end
        chk("cnt_saturated", {16'd0, bus1.borr_cnt}, 32'h0000FFFF);
        do_reset("cnt_reset");
        chk("cnt_cleared", {16'd0, bus1.borr_cnt}, 32'h00000000);
`endif

        // Final reset mid-stream discards the presented operands
        step1(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "pre_reset");
        do_reset("final_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
